// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes, functs, ALU codes, mux selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a. JUMP_LINK_EN adds the JAL/JR states to the state type.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_WB_R,
    ST_EXEC_I,
    ST_WB_I,
    ST_MEM_ADR,
    ST_MEM_RD,
    ST_WB_LW,
    ST_MEM_WR,
    ST_BRANCH,
    ST_JUMP
`ifdef JUMP_LINK_EN
    , ST_JAL
    , ST_JR
`endif
  } state_t;

  // Which ALU function family a state asks for; NONE drives alu_ctrl to zero.
  typedef enum logic [2:0] {
    ALU_CLS_NONE,
    ALU_CLS_ADD,
    ALU_CLS_SUB,
    ALU_CLS_RTYPE,
    ALU_CLS_ITYPE
  } alu_cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_SEXT    = 2'b10;
  localparam logic [1:0] SRC_B_SEXT_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Maps the requesting state class plus opcode/funct to the ALU function code and flags known R-type functs.
// Latency: purely combinational.
// Backpressure: none.
module alu_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_vld
);

  logic [2:0] funct_alu;

  // R-type funct to ALU code; funct_vld only covers the ALU functs (jr is handled by the FSM).
  always_comb begin
    funct_alu = ALU_ADD;
    funct_vld = 1'b1;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_vld = 1'b0;
    endcase
  end

  // Select the ALU code for the class the current state requests.
  always_comb begin
    alu_ctrl = 3'b000;
    case (cls)
      ALU_CLS_ADD:   alu_ctrl = ALU_ADD;
      ALU_CLS_SUB:   alu_ctrl = ALU_SUB;
      ALU_CLS_RTYPE: alu_ctrl = funct_alu;
      ALU_CLS_ITYPE: begin
        case (opcode)
          OP_ANDI: alu_ctrl = ALU_AND;
          OP_SLTI: alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default:       alu_ctrl = 3'b000;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore control FSM for the multi-cycle MIPS core; JUMP_LINK_EN enables jal/jr decode.
// Latency: 2-5 cycles per instruction, outputs decoded from state (pc_ld in BRANCH also uses zero).
// Backpressure: none; memory is combinational so every state lasts exactly one cycle.
module multi_cycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_ld,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic       illegal
);

  state_t   state;
  state_t   state_nxt;
  alu_cls_t alu_cls;
  logic     funct_vld;

  alu_ctrl_decode u_alu_ctrl_decode (
    .cls       (alu_cls),
    .opcode    (opcode),
    .funct     (funct),
    .alu_ctrl  (alu_ctrl),
    .funct_vld (funct_vld)
  );

  // State register; reset abandons any instruction in flight and restarts at FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  // Next-state and per-state control outputs; anything not driven in a state stays 0.
  always_comb begin
    state_nxt  = ST_FETCH;
    alu_cls    = ALU_CLS_NONE;
    pc_ld      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = M2R_ALUOUT;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    pc_src     = PC_SRC_ALU;
    illegal    = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        alu_cls   = ALU_CLS_ADD;
        pc_src    = PC_SRC_ALU;
        pc_ld     = 1'b1;
        state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        alu_src_b = SRC_B_SEXT_SH;
        alu_cls   = ALU_CLS_ADD;
        case (opcode)
          OP_RTYPE: begin
`ifdef JUMP_LINK_EN
            if (funct == FN_JR)  state_nxt = ST_JR;
            else if (funct_vld)  state_nxt = ST_EXEC_R;
            else                 illegal   = 1'b1;
`else
            if (funct_vld) state_nxt = ST_EXEC_R;
            else           illegal   = 1'b1;
`endif
          end
          OP_LW, OP_SW:               state_nxt = ST_MEM_ADR;
          OP_BEQ:                     state_nxt = ST_BRANCH;
          OP_J:                       state_nxt = ST_JUMP;
`ifdef JUMP_LINK_EN
          OP_JAL:                     state_nxt = ST_JAL;
`endif
          OP_ADDI, OP_ANDI, OP_SLTI:  state_nxt = ST_EXEC_I;
          default:                    illegal   = 1'b1;
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_REG;
        alu_cls   = ALU_CLS_RTYPE;
        state_nxt = ST_WB_R;
      end
      ST_WB_R: begin
        reg_dst   = REG_DST_RD;
        reg_write = 1'b1;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_SEXT;
        alu_cls   = ALU_CLS_ITYPE;
        state_nxt = ST_WB_I;
      end
      ST_WB_I: begin
        reg_dst   = REG_DST_RT;
        reg_write = 1'b1;
      end
      ST_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_SEXT;
        alu_cls   = ALU_CLS_ADD;
        state_nxt = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        i_or_d    = 1'b1;
        mem_read  = 1'b1;
        state_nxt = ST_WB_LW;
      end
      ST_WB_LW: begin
        reg_dst    = REG_DST_RT;
        mem_to_reg = M2R_MDR;
        reg_write  = 1'b1;
      end
      ST_MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_REG;
        alu_cls   = ALU_CLS_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_ld     = zero;
      end
      ST_JUMP: begin
        pc_src = PC_SRC_JUMP;
        pc_ld  = 1'b1;
      end
`ifdef JUMP_LINK_EN
      ST_JAL: begin
        reg_dst    = REG_DST_R31;
        mem_to_reg = M2R_PC;
        reg_write  = 1'b1;
        pc_src     = PC_SRC_JUMP;
        pc_ld      = 1'b1;
      end
      ST_JR: begin
        pc_src = PC_SRC_REG;
        pc_ld  = 1'b1;
      end
`endif
      default: state_nxt = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller: directed literal checks, then random instructions vs a sequence model.
// Latency: each instruction's expected per-cycle control words are queued and compared on the falling edge.
// Backpressure: none; every drain wait is bounded by a cycle budget.
`timescale 1ns/1ps
module tb_multi_cycle_controller;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_ld, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a, illegal;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic [2:0] alu_ctrl;

  multi_cycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pc_ld      (pc_ld),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .pc_src     (pc_src),
    .illegal    (illegal)
  );

`ifdef JUMP_LINK_EN
  localparam bit JL = 1'b1;
`else
  localparam bit JL = 1'b0;
`endif

  typedef struct packed {
    logic       pc_ld;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       illegal;
  } ctl_t;

  ctl_t act;
  ctl_t exp_c;
  ctl_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   budget;
  int   sel;
  logic [5:0] r_op, r_fn;
  logic [5:0] fn_tab [6];

  assign act = {pc_ld, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal};

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t (op=%b fn=%b)", name, a, e, $time, opcode, funct);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  // Queue the per-cycle control words an instruction must produce, FETCH through its last state.
  function automatic void build(input logic [5:0] op, input logic [5:0] fn, input logic z);
    ctl_t c;
    bit   is_r, jr, legal, is_i;
    is_r  = (op == 6'h00);
    jr    = JL && is_r && (fn == 6'h08);
    is_i  = op inside {6'h08, 6'h0c, 6'h0a};
    legal = (is_r && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a} || jr)) ||
            is_i || op inside {6'h23, 6'h2b, 6'h04, 6'h02} || (JL && op == 6'h03);
    c = '0; c.pc_ld = 1; c.mem_read = 1; c.ir_write = 1; c.alu_src_b = 2'b01; c.alu_ctrl = 3'b010;
    exp_q.push_back(c);
    c = '0; c.alu_src_b = 2'b11; c.alu_ctrl = 3'b010; c.illegal = !legal;
    exp_q.push_back(c);
    if (!legal) return;
    c = '0;
    if (jr) begin
      c.pc_src = 2'b11; c.pc_ld = 1; exp_q.push_back(c);
    end else if (is_r) begin
      c.alu_src_a = 1; c.alu_ctrl = r_alu(fn); exp_q.push_back(c);
      c = '0; c.reg_dst = 2'b01; c.reg_write = 1; exp_q.push_back(c);
    end else if (is_i) begin
      c.alu_src_a = 1; c.alu_src_b = 2'b10;
      c.alu_ctrl = (op == 6'h0c) ? 3'b000 : (op == 6'h0a) ? 3'b111 : 3'b010;
      exp_q.push_back(c);
      c = '0; c.reg_write = 1; exp_q.push_back(c);
    end else if (op == 6'h23 || op == 6'h2b) begin
      c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctrl = 3'b010; exp_q.push_back(c);
      c = '0; c.i_or_d = 1;
      if (op == 6'h23) begin
        c.mem_read = 1; exp_q.push_back(c);
        c = '0; c.mem_to_reg = 2'b01; c.reg_write = 1; exp_q.push_back(c);
      end else begin
        c.mem_write = 1; exp_q.push_back(c);
      end
    end else if (op == 6'h04) begin
      c.alu_src_a = 1; c.alu_ctrl = 3'b110; c.pc_src = 2'b01; c.pc_ld = z; exp_q.push_back(c);
    end else if (op == 6'h02) begin
      c.pc_src = 2'b10; c.pc_ld = 1; exp_q.push_back(c);
    end else begin
      c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; c.reg_write = 1; c.pc_src = 2'b10; c.pc_ld = 1;
      exp_q.push_back(c);
    end
  endfunction

  // Per-cycle compare against the queued model words, plus invariants that hold in every state.
  always @(negedge clk) begin
    chk("mem_rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
`ifndef JUMP_LINK_EN
    chk("pc_src_never_11", 32'(pc_src == 2'b11), 32'd0);
`endif
    if (!rst && exp_q.size() != 0) begin
      exp_c = exp_q.pop_front();
      chk("ctl_word", {13'd0, act}, {13'd0, exp_c});
    end
  end

  initial begin
    rst = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24;
    fn_tab[3] = 6'h25; fn_tab[4] = 6'h2a; fn_tab[5] = 6'h08;

    // Reset shows the FETCH decode and never writes memory.
    #2;
    chk("rst_mem_read", 32'(mem_read), 32'd1);
    chk("rst_ir_write", 32'(ir_write), 32'd1);
    chk("rst_pc_ld", 32'(pc_ld), 32'd1);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    #10;
    chk("rst_mem_write_late", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // lw walk-through: FETCH DECODE MEM_ADR MEM_RD WB_LW.
    opcode = 6'b100011;
    chk("lw_fetch_ir_write", 32'(ir_write), 32'd1);
    chk("lw_fetch_i_or_d", 32'(i_or_d), 32'd0);
    step(); chk("lw_decode_srcb", 32'(alu_src_b), 32'd3);
    step(); chk("lw_adr_srcb", 32'(alu_src_b), 32'd2);
    chk("lw_adr_i_or_d", 32'(i_or_d), 32'd0);
    step(); chk("lw_rd_i_or_d", 32'(i_or_d), 32'd1);
    chk("lw_rd_mem_read", 32'(mem_read), 32'd1);
    chk("lw_rd_reg_write", 32'(reg_write), 32'd0);
    step(); chk("lw_wb_reg_write", 32'(reg_write), 32'd1);
    chk("lw_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
    chk("lw_wb_mem_read", 32'(mem_read), 32'd0);
    step(); chk("lw_back_fetch", 32'(ir_write), 32'd1);

    // slt: EXEC_R carries 111, WB_R writes rd, FETCH on cycle 5.
    opcode = 6'b000000; funct = 6'b101010;
    step(); step(); chk("slt_alu_ctrl", 32'(alu_ctrl), 32'd7);
    step(); chk("slt_reg_dst", 32'(reg_dst), 32'd1);
    chk("slt_reg_write", 32'(reg_write), 32'd1);
    step(); chk("slt_fetch_cycle5", 32'(ir_write), 32'd1);

    // beq not taken then taken.
    opcode = 6'b000100; zero = 1'b0;
    step(); step(); chk("beq_nt_pc_ld", 32'(pc_ld), 32'd0);
    chk("beq_nt_pc_src", 32'(pc_src), 32'd1);
    chk("beq_alu_sub", 32'(alu_ctrl), 32'd6);
    step(); chk("beq_nt_fetch", 32'(ir_write), 32'd1);
    zero = 1'b1;
    step(); step(); chk("beq_t_pc_ld", 32'(pc_ld), 32'd1);
    chk("beq_t_pc_src", 32'(pc_src), 32'd1);
    step(); chk("beq_t_fetch", 32'(ir_write), 32'd1);

    // Unsupported opcode: one-cycle illegal pulse, no writes, straight back to FETCH.
    opcode = 6'b111111;
    step(); chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_reg_write", 32'(reg_write), 32'd0);
    chk("ill_mem_write", 32'(mem_write), 32'd0);
    step(); chk("ill_gone", 32'(illegal), 32'd0);
    chk("ill_fetch", 32'(ir_write), 32'd1);

    // jal is legal only with the jump-and-link build.
    opcode = 6'b000011;
    step();
`ifdef JUMP_LINK_EN
    chk("jal_legal", 32'(illegal), 32'd0);
    step(); chk("jal_reg_dst", 32'(reg_dst), 32'd2);
    chk("jal_pc_src", 32'(pc_src), 32'd2);
`else
    chk("jal_illegal", 32'(illegal), 32'd1);
`endif
    step(); chk("jal_fetch", 32'(ir_write), 32'd1);

    // Reset in the middle of MEM_WR kills the write at once.
    opcode = 6'b101011;
    step(); step(); step();
    chk("sw_memwr_write", 32'(mem_write), 32'd1);
    chk("sw_memwr_i_or_d", 32'(i_or_d), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("sw_rst_write_drop", 32'(mem_write), 32'd0);
    chk("sw_rst_fetch", 32'(ir_write), 32'd1);
    chk("sw_rst_i_or_d", 32'(i_or_d), 32'd0);
    step();
    chk("sw_rst_held_write", 32'(mem_write), 32'd0);
    rst = 1'b0;

    // Random instruction stream compared against the sequence model.
    for (int n = 0; n < 300; n++) begin
      sel  = $urandom_range(0, 9);
      r_fn = fn_tab[$urandom_range(0, 5)];
      case (sel)
        0, 1: r_op = 6'b000000;
        2:    r_op = 6'b100011;
        3:    r_op = 6'b101011;
        4:    r_op = 6'b000100;
        5:    r_op = 6'b000010;
        6:    r_op = 6'b000011;
        7:    begin
          r_op = 6'b001000;
          if ($urandom_range(0, 2) == 1) r_op = 6'b001100;
          else if ($urandom_range(0, 1) == 1) r_op = 6'b001010;
        end
        8:    r_op = 6'($urandom);
        default: begin r_op = 6'b000000; r_fn = 6'($urandom); end
      endcase
      opcode = r_op; funct = r_fn; zero = 1'($urandom);
      build(r_op, r_fn, zero);
      budget = 0;
      while (exp_q.size() != 0 && budget < 20) begin
        @(negedge clk); #1;
        budget++;
      end
      chk("seq_drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
